seg7_pattern_reader: RTL and testbench
======================================

# seg7_pattern_reader

Serial receiver that captures a 7-bit seven-segment pattern (one segment per clock) and decodes it back to the 4-bit hex value that our segment encoders produce. It is the return path for the display driver blocks: a test harness or a second tile shifts in the pattern a driver emitted, and this block reports the digit, validity, framing/pattern errors and a repeat flag on the tile outputs. It uses the standard 8-in/8-out tile pinout.

## Interface
Parameters: none.

Ports:
- io_in[7]  input  1  clock; all state updates on the rising edge.
- io_in[6]  input  1  reset; asynchronous, active-high.
- io_in[0]  input  1  seg_bit; serial segment data, active-high segment on.
- io_in[1]  input  1  load; frame qualifier, high while bits are being shifted.
- io_in[5:2]  input  4  unused, ignored.
- io_out[3:0]  output  4  digit; last decoded value.
- io_out[4]  output  1  valid; the last completed frame decoded to a legal pattern.
- io_out[5]  output  1  dup; the valid digit equals the previous valid digit.
- io_out[6]  output  1  err; last frame was illegal or aborted.
- io_out[7]  output  1  busy; a frame is partially received.

## Operation
- Pattern bit order: segment A first, then B, C, D, E, F, G. The 7-bit pattern value has A in bit 0 and G in bit 6.
- Legal patterns (hex digit: pattern): 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F. With hex enabled, these are also legal: A:77, b:7C, C:39, d:5E, E:79, F:71.
- States: IDLE (count=0) and SHIFT (count 1..6). There is no separate decode state.
- IDLE, edge with load=1: seg_bit is stored as segment A. count=1, busy=1, valid=0, err=0, dup=0.
- SHIFT, edge with load=1, count<6: the bit is stored and count increments.
- SHIFT, edge with load=1, count=6 (7th bit):
  - The full pattern is decoded in the same edge and count returns to 0.
  - On a match: digit=value, valid=1, err=0. dup=1 only if a previous valid digit exists and equals the new value. The new value becomes the previous valid digit.
  - On no match: valid=0, err=1, dup=0. digit holds its value and the previous valid digit is unchanged.
  - busy=0.
- SHIFT, edge with load=0: the frame is aborted. err=1, valid=0, dup=0, busy=0, count=0. digit and the previous valid digit are held.
- IDLE, edge with load=0: nothing changes. Results are held indefinitely.
- Back-to-back frames: if load stays high after the 7th bit, the next edge starts a new frame as segment A, which clears valid, err and dup.
- Unused io_in bits have no effect.

## Timing
- Reset (asynchronous, any state): count=0, shift register=0, digit=0, valid=0, dup=0, err=0, busy=0, previous-valid-digit marker cleared.
- Reset released mid-frame: the partial frame is lost and the next load=1 edge is segment A.
- Latency: results are visible after the edge that samples the 7th bit (0 extra cycles).
- busy is high from after the 1st sampled bit until the 7th bit or an abort.
- A frame takes exactly 7 consecutive load=1 edges.
- valid, err and dup are all registered outputs; there are no combinational paths from io_in to io_out.
- Maximum throughput: one frame per 7 clocks.

## Configuration
- SEG7_PATTERN_READER_HEX_EN defined: the full 0-F table is legal.
- SEG7_PATTERN_READER_HEX_EN undefined: only 0-9 are legal. Patterns 77, 7C, 39, 5E, 79 and 71 give err=1 and valid=0 like any other illegal pattern.
- Framing, abort and dup behaviour are identical in both builds.

## Test plan
- Reset asserted mid-frame (after 3 bits), then released; send 0x5B (bits 1,1,0,1,1,0,1) with load=1 -> digit=2, valid=1, err=0, dup=0, busy=0 after the 7th edge. All outputs must be 0 during reset.
- Send 0x06, then immediately 0x06 back-to-back with load held high -> second frame gives digit=1, valid=1, dup=1. valid must read 0 during the second frame while busy=1.
- Send 0x7F, then drop load after 4 bits -> err=1, valid=0, busy=0, digit stays 8. A following 0x3F frame gives digit=0, valid=1, dup=0.
- Send illegal 0x00, then 0x40 -> err=1, valid=0 for each, digit unchanged. Next legal 0x3F gives dup=0 when the previous valid digit was not 0.
- Send 0x77 and 0x71 -> hex build gives digit=A then F with valid=1. Non-hex build gives err=1, valid=0 for both.
- Toggle io_in[5:2] randomly throughout any of the above -> no change in any output.

Source files
------------

// File: rtl/seg7_pattern_reader.sv
// Serial seven-segment pattern receiver: shifts in segments A..G, one per clock,
// and decodes the 7-bit pattern back to its hex digit. Build option: SEG7_PATTERN_READER_HEX_EN.
module seg7_pattern_reader (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic clk;
    logic rst;
    logic seg_bit;
    logic load;
    logic unused_pins;

    assign clk         = io_in[7];
    assign rst         = io_in[6];
    assign seg_bit     = io_in[0];
    assign load        = io_in[1];
    assign unused_pins = &{1'b0, io_in[5:2]};

    state_t     state_q,   state_d;
    logic [2:0] count_q,   count_d;
    logic [5:0] shreg_q,   shreg_d;
    logic [3:0] digit_q,   digit_d;
    logic       valid_q,   valid_d;
    logic       dup_q,     dup_d;
    logic       err_q,     err_d;
    logic [3:0] prev_q,    prev_d;
    logic       prev_vq,   prev_vd;

    logic [6:0] pattern;
    logic       hit;
    logic [3:0] value;

    // The 7th bit (G) arrives live; the first six live in the shift register.
    assign pattern = {seg_bit, shreg_q};

    // Pattern-to-digit lookup; the hex letters are only legal in the hex build.
    always_comb begin
        hit   = 1'b1;
        value = 4'h0;
        case (pattern)
            7'h3F: value = 4'h0;
            7'h06: value = 4'h1;
            7'h5B: value = 4'h2;
            7'h4F: value = 4'h3;
            7'h66: value = 4'h4;
            7'h6D: value = 4'h5;
            7'h7D: value = 4'h6;
            7'h07: value = 4'h7;
            7'h7F: value = 4'h8;
            7'h6F: value = 4'h9;
`ifdef SEG7_PATTERN_READER_HEX_EN
            7'h77: value = 4'hA;
            7'h7C: value = 4'hB;
            7'h39: value = 4'hC;
            7'h5E: value = 4'hD;
            7'h79: value = 4'hE;
            7'h71: value = 4'hF;
`endif
            default: hit = 1'b0;
        endcase
    end

    // Frame sequencing, decode on the 7th bit, abort handling and dup tracking.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shreg_d = shreg_q;
        digit_d = digit_q;
        valid_d = valid_q;
        dup_d   = dup_q;
        err_d   = err_q;
        prev_d  = prev_q;
        prev_vd = prev_vq;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = {seg_bit, shreg_q[5:1]};
                    count_d = 3'd1;
                    state_d = SHIFT;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    dup_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (!load) begin
                    state_d = IDLE;
                    count_d = 3'd0;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    dup_d   = 1'b0;
                end else if (count_q == 3'd6) begin
                    state_d = IDLE;
                    count_d = 3'd0;
                    if (hit) begin
                        digit_d = value;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                        dup_d   = prev_vq && (prev_q == value);
                        prev_d  = value;
                        prev_vd = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                        dup_d   = 1'b0;
                    end
                end else begin
                    shreg_d = {seg_bit, shreg_q[5:1]};
                    count_d = count_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 3'd0;
            end
        endcase
    end

    // State and result registers; reset clears everything including the dup marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            shreg_q <= 6'd0;
            digit_q <= 4'd0;
            valid_q <= 1'b0;
            dup_q   <= 1'b0;
            err_q   <= 1'b0;
            prev_q  <= 4'd0;
            prev_vq <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            dup_q   <= dup_d;
            err_q   <= err_d;
            prev_q  <= prev_d;
            prev_vq <= prev_vd;
        end
    end

    assign io_out = {state_q == SHIFT, err_q, dup_q, valid_q, digit_q};

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Directed bench for seg7_pattern_reader; expected io_out values are
// hand-computed as {busy, err, dup, valid, digit}.
module tb_seg7_pattern_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seg = 1'b0;
    logic       load = 1'b0;
    logic [3:0] junk = 4'h0;
    logic [7:0] io_in;
    logic [7:0] io_out;
    int         checks = 0;
    int         fails = 0;

    assign io_in = {clk, rst, junk, load, seg};

    seg7_pattern_reader dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] exp);
        checks++;
        assert (io_out === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, io_out, exp);
        end
    endtask

    // Inputs change on the falling edge; results are read 1 time unit after the rising edge.
    task automatic step(input logic ld, input logic b);
        @(negedge clk);
        load = ld;
        seg  = b;
        junk = 4'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [6:0] pat);
        for (int i = 0; i < 7; i++) step(1'b1, pat[i]);
    endtask

    task automatic bits(input logic [6:0] pat, input int n);
        for (int i = 0; i < n; i++) step(1'b1, pat[i]);
    endtask

    initial begin
        logic [6:0] p;
        #1;
        chk("reset_initial", 8'h00);
        step(1'b0, 1'b0);
        chk("reset_held", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0);
        chk("idle_after_reset", 8'h00);

        p = 7'h5B;
        bits(p, 3);
        chk("partial_busy", 8'h80);
        rst = 1'b1;
        #1;
        chk("async_reset_mid_frame", 8'h00);
        step(1'b1, 1'b1);
        chk("reset_with_load", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;

        frame(7'h5B);
        chk("digit2", 8'h12);

        frame(7'h06);
        chk("digit1_first", 8'h11);
        p = 7'h06;
        step(1'b1, p[0]);
        chk("b2b_busy_valid_low", 8'h81);
        for (int i = 1; i < 7; i++) step(1'b1, p[i]);
        chk("digit1_dup", 8'h31);

        frame(7'h7F);
        chk("digit8", 8'h18);
        bits(7'h7F, 4);
        chk("abort_busy", 8'h88);
        step(1'b0, 1'b1);
        chk("abort_err", 8'h48);
        step(1'b0, 1'b0);
        chk("abort_hold", 8'h48);
        frame(7'h3F);
        chk("digit0_after_abort", 8'h10);

        frame(7'h4F);
        chk("digit3", 8'h13);
        frame(7'h00);
        chk("illegal_00", 8'h43);
        frame(7'h40);
        chk("illegal_40", 8'h43);
        frame(7'h3F);
        chk("digit0_no_dup", 8'h10);
        frame(7'h3F);
        chk("digit0_dup", 8'h30);
        for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom));
        chk("idle_hold_junk", 8'h30);

        frame(7'h6F);
        chk("digit9", 8'h19);
        frame(7'h00);
        chk("illegal_after_9", 8'h49);
        frame(7'h6F);
        chk("dup_across_illegal", 8'h39);

`ifdef SEG7_PATTERN_READER_HEX_EN
        frame(7'h77);
        chk("hex_A", 8'h1A);
        frame(7'h71);
        chk("hex_F", 8'h1F);
        frame(7'h71);
        chk("hex_F_dup", 8'h3F);
`else
        frame(7'h77);
        chk("nohex_77", 8'h49);
        frame(7'h71);
        chk("nohex_71", 8'h49);
        frame(7'h07);
        chk("digit7", 8'h17);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
